// File: rtl/mcr_ioctl_pkg.sv
// Shared ioctl definitions for the MCR core's HPS upload/download helpers.
package mcr_ioctl_pkg;

  localparam int unsigned IOCTL_ADDR_W = 25;

  localparam logic [7:0] IOCTL_IDX_ROM   = 8'd0;
  localparam logic [7:0] IOCTL_IDX_MOD   = 8'd1;
  localparam logic [7:0] IOCTL_IDX_NVRAM = 8'd4;
  localparam logic [7:0] IOCTL_IDX_DIP   = 8'd254;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } upl_state_t;

  // True when the byte address lies inside a 2**addr_w byte region.
  function automatic logic addr_in_range(input logic [IOCTL_ADDR_W-1:0] addr,
                                         input int unsigned addr_w);
    return (addr >> addr_w) == '0;
  endfunction

endpackage

// File: rtl/nvram_uploader_if.sv
// hps_io upload-side ioctl bundle: hps_io is the master, the NVRAM responder the slave.
interface nvram_uploader_if import mcr_ioctl_pkg::*; ();

  logic                    ioctl_upload;
  logic                    ioctl_rd;
  logic [7:0]              ioctl_index;
  logic [IOCTL_ADDR_W-1:0] ioctl_addr;
  logic [7:0]              ioctl_din;
  logic                    ioctl_wait;

  modport master (
    output ioctl_upload,
    output ioctl_rd,
    output ioctl_index,
    output ioctl_addr,
    input  ioctl_din,
    input  ioctl_wait
  );

  modport slave (
    input  ioctl_upload,
    input  ioctl_rd,
    input  ioctl_index,
    input  ioctl_addr,
    output ioctl_din,
    output ioctl_wait
  );

endinterface

// File: rtl/nvram_dirty_tracker.sv
// Tracks CPU writes to NVRAM and clears the dirty flag once an upload that
// actually read NVRAM contents has finished.
module nvram_dirty_tracker (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic sel,
  input  logic rd_done,
  input  logic cpu_we,
  output logic dirty
);

  logic sel_q;
  logic read_seen;
  logic sel_fall;

  assign sel_fall = sel_q & ~sel;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      sel_q     <= 1'b0;
      read_seen <= 1'b0;
      dirty     <= 1'b0;
    end else begin
      sel_q     <= sel;
      // A read finishing on the very edge sel drops still counts for this upload.
      read_seen <= sel_fall ? 1'b0 : (read_seen | rd_done);
      if (cpu_we)
        dirty <= 1'b1;
      else if (sel_fall && (read_seen || rd_done))
        dirty <= 1'b0;
    end
  end

endmodule

// File: rtl/nvram_uploader.sv
// Serves NVRAM bytes to hps_io during an NVRAM save, stalling hps_io via
// ioctl_wait while the dpram read completes, and pausing the CPU meanwhile.
module nvram_uploader import mcr_ioctl_pkg::*; #(
  parameter int unsigned ADDR_W     = 8,
  parameter logic [7:0]  NV_INDEX   = IOCTL_IDX_NVRAM,
  parameter int unsigned RD_LATENCY = 1,
  parameter logic [7:0]  FILL       = 8'hFF
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  nvram_uploader_if.slave   ioctl,
  output logic [ADDR_W-1:0] nv_addr,
  output logic              nv_rd,
  input  logic [7:0]        nv_q,
  input  logic              nv_cpu_we,
  output logic              cpu_hold,
  output logic              nv_dirty
);

  upl_state_t state;
  logic [1:0] cnt;
  logic       fill_pend;
  logic       sel;
  logic       rd_done;

  assign sel     = ioctl.ioctl_upload && (ioctl.ioctl_index == NV_INDEX);
  assign rd_done = (state == DONE) && !fill_pend;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state            <= IDLE;
      cnt              <= '0;
      fill_pend        <= 1'b0;
      nv_addr          <= '0;
      nv_rd            <= 1'b0;
      cpu_hold         <= 1'b0;
      ioctl.ioctl_din  <= '0;
      ioctl.ioctl_wait <= 1'b0;
    end else begin
      nv_rd    <= 1'b0;
      cpu_hold <= sel | (cpu_hold & (state != IDLE));
      case (state)
        IDLE: begin
          if (ioctl.ioctl_rd && sel) begin
            nv_addr          <= ioctl.ioctl_addr[ADDR_W-1:0];
            ioctl.ioctl_wait <= 1'b1;
            if (addr_in_range(ioctl.ioctl_addr, ADDR_W)) begin
              nv_rd     <= 1'b1;
              cnt       <= 2'(RD_LATENCY);
              fill_pend <= 1'b0;
              state     <= FETCH;
            end else begin
              fill_pend <= 1'b1;
              state     <= DONE;
            end
          end
        end
        // DONE samples nv_q, so FETCH leaves once RD_LATENCY cycles have elapsed.
        FETCH: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1)
            state <= DONE;
        end
        DONE: begin
          ioctl.ioctl_din  <= fill_pend ? FILL : nv_q;
          ioctl.ioctl_wait <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  nvram_dirty_tracker u_dirty (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .sel     (sel),
    .rd_done (rd_done),
    .cpu_we  (nv_cpu_we),
    .dirty   (nv_dirty)
  );

  a_rd_in_fetch: assert property (@(posedge clk_sys) disable iff (!reset_n)
    nv_rd |-> (state == FETCH));

  a_wait_busy: assert property (@(posedge clk_sys) disable iff (!reset_n)
    ioctl.ioctl_wait |-> (state != IDLE));

endmodule

// File: tb/tb_nvram_uploader.sv
// Bench for nvram_uploader: two instances (read latency 1 and 3) share stimulus
// and are checked every cycle against a transaction-level timing model.
module tb_nvram_uploader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        upload = 1'b0;
  logic        rd = 1'b0;
  logic        cpu_we = 1'b0;
  logic [7:0]  index = 8'd0;
  logic [24:0] addr = '0;
  logic [7:0]  mem [256];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  nvram_uploader_if if1 ();
  nvram_uploader_if if3 ();
  assign if1.ioctl_upload = upload;
  assign if1.ioctl_rd     = rd;
  assign if1.ioctl_index  = index;
  assign if1.ioctl_addr   = addr;
  assign if3.ioctl_upload = upload;
  assign if3.ioctl_rd     = rd;
  assign if3.ioctl_index  = index;
  assign if3.ioctl_addr   = addr;

  logic [7:0] nva1, nva3, q1, q3, s0, s1;
  logic       rd1, rd3, hold1, hold3, dirty1, dirty3;

  nvram_uploader #(.ADDR_W(8), .NV_INDEX(8'd4), .RD_LATENCY(1), .FILL(8'hFF)) u_dut1 (
    .clk_sys(clk), .reset_n(reset_n), .ioctl(if1), .nv_addr(nva1), .nv_rd(rd1),
    .nv_q(q1), .nv_cpu_we(cpu_we), .cpu_hold(hold1), .nv_dirty(dirty1));

  nvram_uploader #(.ADDR_W(8), .NV_INDEX(8'd4), .RD_LATENCY(3), .FILL(8'hFF)) u_dut3 (
    .clk_sys(clk), .reset_n(reset_n), .ioctl(if3), .nv_addr(nva3), .nv_rd(rd3),
    .nv_q(q3), .nv_cpu_we(cpu_we), .cpu_hold(hold3), .nv_dirty(dirty3));

  // dpram read ports; data is valid for exactly one cycle, junk otherwise
  always @(posedge clk) begin
    q1 <= rd1 ? mem[nva1] : 8'h5A;
    s0 <= rd3 ? mem[nva3] : 8'h5A;
    s1 <= s0;
    q3 <= s1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted read keeps wait high for L+1 cycles
  // (1 if out of range), then presents the byte.
  int         lat [2];
  int         left [2];
  logic       m_wait [2], m_nvrd [2], m_hold [2], m_dirty [2], m_selp [2], m_seen [2];
  logic       pend_fill [2];
  logic [7:0] m_din [2], m_nva [2], pend [2];
  logic       ms, mhn, mdone, mfall;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        m_wait[k] = 0; m_nvrd[k] = 0; m_hold[k] = 0; m_dirty[k] = 0;
        m_selp[k] = 0; m_seen[k] = 0; m_din[k] = 8'h00; m_nva[k] = 8'h00; left[k] = 0;
      end else begin
        ms    = upload && (index == 8'd4);
        mhn   = ms || (m_hold[k] && m_wait[k]);
        mdone = 0;
        m_nvrd[k] = 0;
        if (m_wait[k]) begin
          left[k]--;
          if (left[k] == 0) begin
            m_wait[k] = 0;
            m_din[k]  = pend[k];
            mdone     = !pend_fill[k];
          end
        end else if (rd && ms) begin
          m_wait[k] = 1;
          m_nva[k]  = addr[7:0];
          if (addr < 25'd256) begin
            m_nvrd[k] = 1; left[k] = lat[k] + 1; pend[k] = mem[addr[7:0]]; pend_fill[k] = 0;
          end else begin
            left[k] = 1; pend[k] = 8'hFF; pend_fill[k] = 1;
          end
        end
        mfall = m_selp[k] && !ms;
        if (cpu_we) m_dirty[k] = 1;
        else if (mfall && (m_seen[k] || mdone)) m_dirty[k] = 0;
        m_seen[k] = mfall ? 1'b0 : (m_seen[k] || mdone);
        m_selp[k] = ms;
        m_hold[k] = mhn;
      end
    end
  end

  task automatic cmp_dut(input int k, input logic w, input logic [7:0] d, input logic r,
                         input logic [7:0] a, input logic h, input logic dy);
    chk($sformatf("wait_u%0d", k), w, m_wait[k]);
    chk($sformatf("din_u%0d", k), d, m_din[k]);
    chk($sformatf("nv_rd_u%0d", k), r, m_nvrd[k]);
    chk($sformatf("nv_addr_u%0d", k), a, m_nva[k]);
    chk($sformatf("cpu_hold_u%0d", k), h, m_hold[k]);
    chk($sformatf("nv_dirty_u%0d", k), dy, m_dirty[k]);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cmp_dut(0, if1.ioctl_wait, if1.ioctl_din, rd1, nva1, hold1, dirty1);
      cmp_dut(1, if3.ioctl_wait, if3.ioctl_din, rd3, nva3, hold3, dirty3);
    end
  end

  // Issue one strobe, then follow both instances until their wait drops.
  task automatic do_read(input logic [24:0] a, output int w1, output int w3, output int nrd,
                         output logic frd, output logic [7:0] fa);
    w1 = 0; w3 = 0; nrd = 0; frd = 0; fa = '0;
    rd = 1; addr = a;
    @(negedge clk);
    rd = 0;
    for (int n = 0; n < 20; n++) begin
      if (n == 0) begin frd = rd1; fa = nva1; end
      if (if1.ioctl_wait) w1++;
      if (if3.ioctl_wait) w3++;
      nrd += int'(rd1) + int'(rd3);
      if (!if1.ioctl_wait && !if3.ioctl_wait) break;
      @(negedge clk);
    end
  endtask

  int         w1, w3, nrd, n;
  logic       frd;
  logic [7:0] fa, last;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3) ^ 8'h5C;
    mem[8'h12] = 8'hA5;
    lat[0] = 1; lat[1] = 3;

    repeat (3) @(negedge clk);
    chk("rst_din", {if1.ioctl_din, if3.ioctl_din}, 16'h0000);
    chk("rst_wait", {if1.ioctl_wait, if3.ioctl_wait, rd1, rd3}, 4'b0000);
    chk("rst_hold_dirty", {hold1, hold3, dirty1, dirty3}, 4'b0000);
    reset_n = 1;
    @(negedge clk);
    upload = 1; index = 8'd4;
    @(negedge clk);
    chk("hold_on_sel", {hold1, hold3}, 2'b11);

    do_read(25'h12, w1, w3, nrd, frd, fa);
    chk("t1_nv_rd_at_T1", frd, 1'b1);
    chk("t1_nv_addr", fa, 8'h12);
    chk("t1_wait_width_l1", w1, 2);
    chk("t1_wait_width_l3", w3, 4);
    chk("t1_nv_rd_count", nrd, 2);
    chk("t1_din_l1", if1.ioctl_din, 8'hA5);
    chk("t1_din_l3", if3.ioctl_din, 8'hA5);

    for (int i = 0; i < 256; i++) begin
      do_read(25'(i), w1, w3, nrd, frd, fa);
      chk("sweep_wait_l3", w3, 4);
      chk("sweep_wait_l1", w1, 2);
      chk("sweep_din_l3", if3.ioctl_din, mem[i]);
    end

    for (int j = 0; j < 2; j++) begin
      do_read(j == 0 ? 25'h100 : 25'h1FFFFFF, w1, w3, nrd, frd, fa);
      chk("oor_wait_l1", w1, 1);
      chk("oor_wait_l3", w3, 1);
      chk("oor_no_nv_rd", nrd, 0);
      chk("oor_fill", {if1.ioctl_din, if3.ioctl_din}, 16'hFFFF);
    end

    cpu_we = 1;
    @(negedge clk);
    cpu_we = 0;
    chk("dirty_set", {dirty1, dirty3}, 2'b11);
    do_read(25'h30, w1, w3, nrd, frd, fa);
    upload = 0;
    repeat (2) @(negedge clk);
    chk("dirty_cleared", {dirty1, dirty3}, 2'b00);
    chk("hold_released", {hold1, hold3}, 2'b00);

    upload = 1;
    @(negedge clk);
    cpu_we = 1;
    @(negedge clk);
    cpu_we = 0;
    do_read(25'h31, w1, w3, nrd, frd, fa);
    last = mem[8'h31];
    upload = 0; cpu_we = 1;
    @(negedge clk);
    cpu_we = 0;
    @(negedge clk);
    chk("dirty_set_wins", {dirty1, dirty3}, 2'b11);

    upload = 1; index = 8'd1; rd = 1; addr = 25'h5;
    @(negedge clk);
    rd = 0;
    repeat (3) begin
      chk("idx1_wait", {if1.ioctl_wait, if3.ioctl_wait}, 2'b00);
      chk("idx1_hold", {hold1, hold3}, 2'b00);
      chk("idx1_din", if3.ioctl_din, last);
      @(negedge clk);
    end
    index = 8'd4;
    @(negedge clk);

    rd = 1; addr = 25'h22;
    @(negedge clk);
    rd = 0; upload = 0;
    n = 0;
    while ((if1.ioctl_wait || if3.ioctl_wait) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drop_timeout", n < 20, 1'b1);
    chk("drop_din", {if1.ioctl_din, if3.ioctl_din}, {mem[8'h22], mem[8'h22]});
    chk("drop_hold_still", hold3, 1'b1);
    @(negedge clk);
    chk("drop_hold_released", {hold1, hold3}, 2'b00);

    upload = 1;
    @(negedge clk);
    rd = 1; addr = 25'h40;
    @(negedge clk);
    rd = 0; reset_n = 0;
    @(negedge clk);
    chk("midrst_wait", {if1.ioctl_wait, if3.ioctl_wait, rd1, rd3}, 4'b0000);
    chk("midrst_din", {if1.ioctl_din, if3.ioctl_din}, 16'h0000);
    chk("midrst_hold", {hold1, hold3}, 2'b00);
    reset_n = 1;
    @(negedge clk);
    do_read(25'h41, w1, w3, nrd, frd, fa);
    chk("post_rst_wait_l3", w3, 4);
    chk("post_rst_din", {if1.ioctl_din, if3.ioctl_din}, {mem[8'h41], mem[8'h41]});

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
